mips_run_ctrl: RTL
==================

# mips_run_ctrl

Run controller for the pipelined MIPS core in simulation and on-board bring-up. Sits between the bench/board clock-reset source and `mips`. It generates a stretched core reset, counts executed cycles and detects program termination. Termination is either a dedicated halt instruction or the `beq $0,$0,-1` self-loop idiom. A cycle budget ends runaway programs with a timeout flag. It supersedes the bare free-running clock/reset harness and adds parameterised reset stretch, halt detection and soft restart.

## Interface
Parameters:
- `RST_CYCLES`, 4: cycles `core_reset` is held high after reset or restart (≥1).
- `CNT_W`, 32: width of `cycle_count`.
- `MAX_CYCLES`, 100000: RUN-cycle budget before timeout (≥1, < 2^CNT_W).
- `LOOP_THRESH`, 3: consecutive valid fetches of the same PC that count as halt (≥2).
- `HALT_INSTR`, 32'hFFFF_FFFF: instruction word treated as explicit halt.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `restart`, in, 1: synchronous soft restart pulse.
- `pc`, in, 32: IF-stage PC from core.
- `instr`, in, 32: IF-stage fetched instruction.
- `pc_valid`, in, 1: IF stage fetched this cycle (not stalled/flushed).
- `core_reset`, out, 1: reset to `mips`, synchronous deassert.
- `running`, out, 1: high in RUN.
- `done`, out, 1: sticky, program halted.
- `timeout`, out, 1: sticky, budget exhausted.
- `halt_pc`, out, 32: PC at which halt was detected.
- `cycle_count`, out, CNT_W: RUN cycles elapsed.

## Operation
- States are HOLD, RUN, DONE and TOUT.
- `reset` high: async entry to HOLD, with hold counter 0, `core_reset`=1, `running`=0, `done`=0, `timeout`=0, `halt_pc`=0, `cycle_count`=0, repeat counter 0 and last-PC-valid flag 0.
- HOLD: the hold counter increments every edge. On the edge where it equals RST_CYCLES-1, go to RUN. `core_reset` is the registered state≠RUN-or-later and is 0 from the first RUN cycle.
- RUN: `cycle_count` increments on every RUN edge, including the terminating edge. It saturates at all-ones.
- Halt condition in a RUN cycle:
  - `pc_valid` && `instr`==HALT_INSTR, or
  - `pc_valid` && the same PC seen on LOOP_THRESH consecutive valid cycles.
- Repeat counter, on a valid cycle:
  - If last-PC-valid && `pc`==last_pc, increment (saturating at LOOP_THRESH).
  - Otherwise set it to 1.
  - Then last_pc←`pc` and last-PC-valid←1.
- Cycles with `pc_valid`=0 leave the repeat counter and last_pc unchanged; stalls do not break or form a loop.
- Halt: next state is DONE, `done`←1 and `halt_pc`←`pc`.
- Timeout: no halt, and `cycle_count`==MAX_CYCLES-1 at the edge. Next state is TOUT, `timeout`←1 and `cycle_count` becomes MAX_CYCLES.
- Halt and timeout in the same cycle: halt wins; `done`=1, `timeout`=0.
- DONE/TOUT are terminal. `cycle_count` and `halt_pc` are frozen. `core_reset` stays 0 so architectural state can be dumped.
- `restart`=1 in any state, including mid-HOLD and mid-RUN:
  - Next state is HOLD.
  - Clear the hold counter, `cycle_count`, `done`, `timeout`, `halt_pc`, the repeat counter and the last-PC-valid flag.
  - `core_reset` is 1 the following cycle.
  - `restart` has priority over halt and timeout in the same cycle.

## Timing
- `reset` deassertion is treated as synchronous to `clk`. With reset released before edge 0, `core_reset` falls after edge RST_CYCLES-1, so exactly RST_CYCLES core-reset edges are seen.
- Halt detection latency: the halt is on the IF cycle of the qualifying fetch. `done` is high one edge later and `running` low the same edge.
- All outputs are registered; no combinational input→output paths.
- `restart` is sampled only on edges; one-cycle pulse suffices; a held `restart` keeps the block in HOLD with the hold counter at 0.

## Test plan
- Default params, release `reset` → `core_reset` high for exactly 4 edges, then `running`=1 and `cycle_count` counts 1, 2, 3….
- Feed PCs 0x3000, 0x3004, 0x3008, 0x3008, 0x3008, all valid → `done`=1 on the edge after the third 0x3008, `halt_pc`=0x3008, `cycle_count`=5.
- Self-loop 0x3010 with `pc_valid` toggling 1,0,1,0,1 → halt only after the third valid sample; `cycle_count`=5.
- `instr`=0xFFFFFFFF at PC 0x3020 on cycle 7 → `done`=1, `halt_pc`=0x3020, `cycle_count`=7.
- MAX_CYCLES=10 with distinct PCs → `timeout`=1, `done`=0, `cycle_count`=10. Then the halt instruction on cycle 10 with MAX_CYCLES=10 → `done`=1, `timeout`=0.
- `restart` pulse at RUN cycle 6 → next cycle HOLD with `cycle_count`=0 and `core_reset`=1 for 4 edges. An async `reset` mid-RUN immediately forces all outputs to their reset values.

Source files
------------

// File: rtl/mips_run_ctrl.sv
// Run controller for the pipelined MIPS core: stretched core reset,
// RUN cycle counting, halt/self-loop detection, timeout and soft restart.
module mips_run_ctrl #(
  parameter int          RST_CYCLES  = 4,
  parameter int          CNT_W       = 32,
  parameter int          MAX_CYCLES  = 100000,
  parameter int          LOOP_THRESH = 3,
  parameter logic [31:0] HALT_INSTR  = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic [31:0]      pc,
  input  logic [31:0]      instr,
  input  logic             pc_valid,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [31:0]      halt_pc,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int RW = $clog2(LOOP_THRESH + 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_DONE,
    S_TOUT
  } state_t;

  state_t           r_state;
  logic [HW-1:0]    r_hold;
  logic [RW-1:0]    r_rep;
  logic [31:0]      r_last_pc;
  logic             r_last_v;
  logic             r_core_reset;
  logic             r_running;
  logic             r_done;
  logic             r_timeout;
  logic [31:0]      r_halt_pc;
  logic [CNT_W-1:0] r_cnt;

  logic             w_same;
  logic [RW-1:0]    w_rep_nxt;
  logic             w_halt;
  logic             w_tout;
  logic             w_hold_end;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_same     = r_last_v && (pc == r_last_pc);
  assign w_rep_nxt  = !w_same ? RW'(1) :
                      (r_rep >= RW'(LOOP_THRESH)) ? r_rep :
                      r_rep + 1'b1;
  assign w_halt     = pc_valid &&
                      ((instr == HALT_INSTR) ||
                       (w_rep_nxt >= RW'(LOOP_THRESH)));
  assign w_tout     = (r_cnt == CNT_W'(MAX_CYCLES - 1));
  assign w_hold_end = (r_hold == HW'(RST_CYCLES - 1));
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_HOLD;
      r_hold       <= '0;
      r_rep        <= '0;
      r_last_pc    <= '0;
      r_last_v     <= 1'b0;
      r_core_reset <= 1'b1;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_halt_pc    <= '0;
      r_cnt        <= '0;
    end else if (restart) begin
      r_state      <= S_HOLD;
      r_hold       <= '0;
      r_rep        <= '0;
      r_last_v     <= 1'b0;
      r_core_reset <= 1'b1;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_halt_pc    <= '0;
      r_cnt        <= '0;
    end else begin
      unique case (r_state)
        S_HOLD: begin
          r_hold <= r_hold + 1'b1;
          if (w_hold_end) begin
            r_state      <= S_RUN;
            r_core_reset <= 1'b0;
            r_running    <= 1'b1;
          end
        end
        S_RUN: begin
          r_cnt <= w_cnt_inc;
          // stalled fetches neither break nor extend a loop
          if (pc_valid) begin
            r_rep     <= w_rep_nxt;
            r_last_pc <= pc;
            r_last_v  <= 1'b1;
          end
          if (w_halt) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_halt_pc <= pc;
            r_running <= 1'b0;
          end else if (w_tout) begin
            r_state   <= S_TOUT;
            r_timeout <= 1'b1;
            r_running <= 1'b0;
          end
        end
        S_DONE, S_TOUT: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign core_reset  = r_core_reset;
  assign running     = r_running;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign halt_pc     = r_halt_pc;
  assign cycle_count = r_cnt;

endmodule
